// File: rtl/h264dc_pkg.sv
// Shared types and constants for the H.264 DC Hadamard block.
//   state_t : controller states
//   mode_t  : block size selected with the first coefficient
//   N_*/R_* : coefficients per block and passes per direction
package h264dc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROW  = 3'd2,
    COL  = 3'd3,
    OUT  = 3'd4
  } state_t;

  typedef enum logic {
    MODE_2X2 = 1'b0,
    MODE_4X4 = 1'b1
  } mode_t;

  localparam int N_2X2 = 4;
  localparam int N_4X4 = 16;
  localparam int R_2X2 = 1;
  localparam int R_4X4 = 4;

  // Raster index of the final coefficient of a block.
  function automatic logic [3:0] last_idx(input mode_t m);
    return (m == MODE_4X4) ? 4'(N_4X4 - 1) : 4'(N_2X2 - 1);
  endfunction

  // Pass down-counter load value; the pass ends when the counter reads 0.
  function automatic logic [1:0] pass_init(input mode_t m);
    return (m == MODE_4X4) ? 2'(R_4X4 - 1) : 2'(R_2X2 - 1);
  endfunction

endpackage

// File: rtl/h264dc_butterfly4.sv
// Combinational 4-point Hadamard butterfly, H4 row order:
//   y0 = a+b+c+d, y1 = a+b-c-d, y2 = a-b-c+d, y3 = a-b+c-d
// Ports:
//   a,b,c,d  in  W    signed operands
//   y0..y3   out W+2  signed results, exact (no overflow possible)
module h264dc_butterfly4 #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] y0,
  output logic signed [W+1:0] y1,
  output logic signed [W+1:0] y2,
  output logic signed [W+1:0] y3
);

  logic signed [W+1:0] ae, be, ce, de;
  logic signed [W+1:0] s_ab, d_ab, s_cd, d_cd;

  assign ae = (W+2)'(a);
  assign be = (W+2)'(b);
  assign ce = (W+2)'(c);
  assign de = (W+2)'(d);

  assign s_ab = ae + be;
  assign d_ab = ae - be;
  assign s_cd = ce + de;
  assign d_cd = ce - de;

  assign y0 = s_ab + s_cd;
  assign y1 = s_ab - s_cd;
  assign y2 = d_ab - d_cd;
  assign y3 = d_ab + d_cd;

endmodule

// File: rtl/h264dc_hadamard.sv
// DC Hadamard transform (2x2 chroma DC or 4x4 Intra16x16 luma DC).
// Coefficients arrive serially in raster order, are buffered, transformed in
// place by a row pass then a column pass, and leave serially in raster order.
// Ports:
//   CLK      in   1   clock, rising edge
//   RESET_N  in   1   asynchronous active-low reset
//   READYI   out  1   block can accept a coefficient
//   ENABLE   in   1   XXIN valid (transfer on ENABLE && READYI)
//   MODE     in   1   0 = 2x2, 1 = 4x4, sampled with the first coefficient
//   XXIN     in   IW  signed input coefficient
//   VALID    out  1   YYOUT valid
//   YYOUT    out  OW  signed result, sign-extended
//   LAST     out  1   final result of the block
//   READYO   in   1   downstream ready (transfer on VALID && READYO)
//
// state | meaning
// IDLE  | waiting for the first coefficient of a block
// LOAD  | storing the remaining coefficients
// ROW   | row pass, one row per cycle (2x2: both rows in one cycle)
// COL   | column pass, one column per cycle (2x2: both columns in one cycle)
// OUT   | presenting results under ready/valid
module h264dc_hadamard
  import h264dc_pkg::*;
#(
  parameter int IW       = 16,
  parameter int OW       = 20,
  parameter int TOGETHER = 0,
  parameter int HALVE4   = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  output logic          READYI,
  input  logic          ENABLE,
  input  logic          MODE,
  input  logic [IW-1:0] XXIN,
  output logic          VALID,
  output logic [OW-1:0] YYOUT,
  output logic          LAST,
  input  logic          READYO
);

  localparam int BW  = IW + 4;   // buffer width, holds final results exactly
  localparam int BFW = IW + 2;   // butterfly operand width (row results fit)

  if (OW < IW + 4) begin : g_bad_ow
    $error("h264dc_hadamard: OW must be at least IW+4");
  end

  state_t              state_q, state_d;
  mode_t               mode_q;
  logic [3:0]          idx_q;
  logic [3:0]          k_q;
  logic [1:0]          pass_q;
  logic                readyi_q;
  logic                valid_q;
  logic                last_q;
  logic                stream_q;
  logic [OW-1:0]       yyout_q;
  logic signed [BW-1:0] coef_q [16];

  logic                xfer_in, xfer_out;
  logic [3:0]          last_in;

  logic signed [BFW-1:0] bf_a, bf_b, bf_c, bf_d;
  logic signed [BW-1:0]  bf_y [4];
  logic signed [BW-1:0]  side_p, side_q, side_sum, side_dif;

  logic [3:0]            k_sel;
  logic signed [BW-1:0]  rd, res;
  logic [OW-1:0]         yy_nx;

  assign xfer_in  = ENABLE && readyi_q;
  // Once streaming has begun with TOGETHER set, the block drains regardless of READYO.
  assign xfer_out = valid_q && (READYO || ((TOGETHER != 0) && stream_q));
  assign last_in  = last_idx(mode_q);

  assign READYI = readyi_q;
  assign VALID  = valid_q;
  assign YYOUT  = yyout_q;
  assign LAST   = last_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer_in) state_d = LOAD;
      LOAD:    if (xfer_in && (idx_q == last_in)) state_d = ROW;
      ROW:     if (pass_q == 2'd0) state_d = COL;
      COL:     if (pass_q == 2'd0) state_d = OUT;
      OUT:     if (xfer_out && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------ butterfly operand mux
  // 2x2 runs one 2-point pair through the butterfly as (a,b,0,0), taking
  // outputs 0 and 2, and the other pair through a small side adder so both
  // rows (or columns) finish in a single cycle.
  always_comb begin
    bf_a   = '0;
    bf_b   = '0;
    bf_c   = '0;
    bf_d   = '0;
    side_p = '0;
    side_q = '0;
    if (state_q == ROW) begin
      if (mode_q == MODE_4X4) begin
        bf_a = BFW'(coef_q[{pass_q, 2'd0}]);
        bf_b = BFW'(coef_q[{pass_q, 2'd1}]);
        bf_c = BFW'(coef_q[{pass_q, 2'd2}]);
        bf_d = BFW'(coef_q[{pass_q, 2'd3}]);
      end else begin
        bf_a   = BFW'(coef_q[0]);
        bf_b   = BFW'(coef_q[1]);
        side_p = coef_q[2];
        side_q = coef_q[3];
      end
    end else if (state_q == COL) begin
      if (mode_q == MODE_4X4) begin
        bf_a = BFW'(coef_q[{2'd0, pass_q}]);
        bf_b = BFW'(coef_q[{2'd1, pass_q}]);
        bf_c = BFW'(coef_q[{2'd2, pass_q}]);
        bf_d = BFW'(coef_q[{2'd3, pass_q}]);
      end else begin
        bf_a   = BFW'(coef_q[0]);
        bf_b   = BFW'(coef_q[2]);
        side_p = coef_q[1];
        side_q = coef_q[3];
      end
    end
  end

  assign side_sum = side_p + side_q;
  assign side_dif = side_p - side_q;

  h264dc_butterfly4 #(.W(BFW)) u_bfly (
    .a  (bf_a),
    .b  (bf_b),
    .c  (bf_c),
    .d  (bf_d),
    .y0 (bf_y[0]),
    .y1 (bf_y[1]),
    .y2 (bf_y[2]),
    .y3 (bf_y[3])
  );

  // ------------------------------------------------- coefficient buffer
  // Contents are don't-care after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (xfer_in) begin
      coef_q[idx_q] <= BW'($signed(XXIN));
    end else if ((state_q == ROW) || (state_q == COL)) begin
      if (mode_q == MODE_4X4) begin
        for (int j = 0; j < 4; j++) begin
          if (state_q == ROW) coef_q[{pass_q, 2'(j)}] <= bf_y[j];
          else                coef_q[{2'(j), pass_q}] <= bf_y[j];
        end
      end else if (state_q == ROW) begin
        coef_q[0] <= bf_y[0];
        coef_q[1] <= bf_y[2];
        coef_q[2] <= side_sum;
        coef_q[3] <= side_dif;
      end else begin
        coef_q[0] <= bf_y[0];
        coef_q[2] <= bf_y[2];
        coef_q[1] <= side_sum;
        coef_q[3] <= side_dif;
      end
    end
  end

  // ------------------------------------------------------- output mux
  // k_q tracks the result currently presented; k_sel is the one to load next.
  assign k_sel = valid_q ? 4'(k_q + 4'd1) : k_q;
  assign rd    = coef_q[k_sel];
  assign res   = ((HALVE4 != 0) && (mode_q == MODE_4X4)) ? (rd >>> 1) : rd;
  assign yy_nx = OW'(res);

  // ------------------------------------------ counters and output register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q   <= MODE_2X2;
      idx_q    <= '0;
      k_q      <= '0;
      pass_q   <= '0;
      readyi_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      stream_q <= 1'b0;
      yyout_q  <= '0;
    end else begin
      readyi_q <= (state_d == IDLE) || (state_d == LOAD);

      if ((state_q == IDLE) && xfer_in) mode_q <= mode_t'(MODE);

      if (xfer_in) idx_q <= (state_d == ROW) ? 4'd0 : 4'(idx_q + 4'd1);

      if (state_d != state_q)   pass_q <= pass_init(mode_q);
      else if (pass_q != 2'd0)  pass_q <= pass_q - 2'd1;

      if (state_q == OUT) begin
        if (!valid_q) begin
          valid_q <= 1'b1;
          yyout_q <= yy_nx;
          last_q  <= (k_sel == last_in);
          k_q     <= k_sel;
        end else if (xfer_out) begin
          if (last_q) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            yyout_q  <= '0;
            k_q      <= '0;
            stream_q <= 1'b0;
          end else begin
            stream_q <= 1'b1;
            yyout_q  <= yy_nx;
            last_q   <= (k_sel == last_in);
            k_q      <= k_sel;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_h264dc_hadamard.sv
// Self-checking bench for h264dc_hadamard. Three instances with different
// parameters share clock/reset/data; each has its own ENABLE/READYO.
//   u0: HALVE4=1 TOGETHER=0   u1: HALVE4=0 TOGETHER=0   u2: HALVE4=1 TOGETHER=1
module tb_h264dc_hadamard;

  localparam int IW = 16;
  localparam int OW = 20;

  logic          CLK     = 1'b0;
  logic          RESET_N = 1'b0;
  logic          MODE    = 1'b0;
  logic [IW-1:0] XXIN    = '0;
  logic [2:0]    en      = '0;
  logic [2:0]    ro      = '0;

  logic          ri0, ri1, ri2, vl0, vl1, vl2, ls0, ls1, ls2;
  logic [OW-1:0] yy0, yy1, yy2;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int h4 [16] = '{1, 1, 1, 1,  1, 1, -1, -1,  1, -1, -1, 1,  1, -1, 1, -1};

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  h264dc_hadamard #(.IW(IW), .OW(OW), .TOGETHER(0), .HALVE4(1)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .READYI(ri0), .ENABLE(en[0]), .MODE(MODE), .XXIN(XXIN),
    .VALID(vl0), .YYOUT(yy0), .LAST(ls0), .READYO(ro[0]));
  h264dc_hadamard #(.IW(IW), .OW(OW), .TOGETHER(0), .HALVE4(0)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .READYI(ri1), .ENABLE(en[1]), .MODE(MODE), .XXIN(XXIN),
    .VALID(vl1), .YYOUT(yy1), .LAST(ls1), .READYO(ro[1]));
  h264dc_hadamard #(.IW(IW), .OW(OW), .TOGETHER(1), .HALVE4(1)) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .READYI(ri2), .ENABLE(en[2]), .MODE(MODE), .XXIN(XXIN),
    .VALID(vl2), .YYOUT(yy2), .LAST(ls2), .READYO(ro[2]));

  function automatic logic ri_of(input int u);
    return (u == 0) ? ri0 : (u == 1) ? ri1 : ri2;
  endfunction
  function automatic logic vl_of(input int u);
    return (u == 0) ? vl0 : (u == 1) ? vl1 : vl2;
  endfunction
  function automatic logic ls_of(input int u);
    return (u == 0) ? ls0 : (u == 1) ? ls1 : ls2;
  endfunction
  function automatic logic [OW-1:0] yy_of(input int u);
    return (u == 0) ? yy0 : (u == 1) ? yy1 : yy2;
  endfunction
  function automatic bit tog_of(input int u);
    return (u == 2);
  endfunction
  function automatic bit halve_of(input int u);
    return (u != 1);
  endfunction

  // Reference: Y = H * X * H^T computed directly as a double sum.
  function automatic void model(input int m4, input bit halve, input longint x[16],
                                output longint y[16]);
    longint s;
    for (int i = 0; i < 16; i++) y[i] = 0;
    if (m4 != 0) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          s = 0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              s += longint'(h4[i*4+r]) * x[r*4+c] * longint'(h4[j*4+c]);
          y[i*4+j] = halve ? (s >>> 1) : s;
        end
    end else begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          s = 0;
          for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
              s += ((i == 1 && r == 1) ? -1 : 1) * x[r*2+c] * ((j == 1 && c == 1) ? -1 : 1);
          y[i*2+j] = s;
        end
    end
  endfunction

  function automatic void rand_block(output longint x[16]);
    logic signed [IW-1:0] r;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(7))
        0:       r = 16'sh8000;
        1:       r = 16'sh7fff;
        default: r = IW'($urandom);
      endcase
      x[i] = longint'(r);
    end
  endfunction

  task automatic send_block(input int u, input int m4, input longint x[16], input int n_send,
                            input bit mode_noise, output int acc_edge);
    int i = 0;
    int budget = 0;
    acc_edge = 0;
    while (i < n_send && budget < 100) begin
      @(negedge CLK);
      MODE  = (mode_noise && i > 0) ? 1'($urandom) : 1'(m4);
      XXIN  = IW'(x[i]);
      en[u] = 1'b1;
      if (ri_of(u)) begin
        acc_edge = cyc + 1;
        i++;
      end
      budget++;
    end
    n_cmp++;
    if (i < n_send) begin
      n_bad++;
      $display("FAIL send_timeout u%0d: accepted %0d, required %0d", u, i, n_send);
    end
  endtask

  task automatic recv_block(input int u, input int m4, input longint expv[16], input int pct,
                            input int acc_edge, input bit keep_en);
    int n = (m4 != 0) ? 16 : 4;
    int lat = (m4 != 0) ? 9 : 3;
    int k = 0;
    int budget = 0;
    bit started = 0, seen = 0, stall = 0, xfer;
    logic v, l, pl;
    logic [OW-1:0] y, py, e;
    py = '0;
    pl = 1'b0;
    while (k < n && budget < 1000) begin
      @(negedge CLK);
      budget++;
      v = vl_of(u);
      y = yy_of(u);
      l = ls_of(u);
      en[u] = keep_en;
      XXIN  = IW'($urandom);
      if (keep_en) begin
        MODE = 1'($urandom);
        n_cmp++;
        if (ri_of(u) !== 1'b0) begin
          n_bad++;
          $display("FAIL readyi_busy u%0d: READYI %b, required 0", u, ri_of(u));
        end
      end
      if (v && !seen) begin
        seen = 1;
        n_cmp++;
        if (cyc - acc_edge != lat) begin
          n_bad++;
          $display("FAIL latency u%0d: %0d cycles, required %0d", u, cyc - acc_edge, lat);
        end
      end
      if (stall) begin
        n_cmp++;
        if (v !== 1'b1 || y !== py || l !== pl) begin
          n_bad++;
          $display("FAIL hold_stable u%0d k=%0d: v=%b y=%0d last=%b, required v=1 y=%0d last=%b",
                   u, k, v, $signed(y), l, $signed(py), pl);
        end
      end
      if (tog_of(u) && started) begin
        n_cmp++;
        if (v !== 1'b1) begin
          n_bad++;
          $display("FAIL together_gap u%0d k=%0d: VALID %b, required 1", u, k, v);
        end
      end
      ro[u] = ($urandom_range(99) < pct);
      xfer = v && (ro[u] || (tog_of(u) && started));
      if (xfer) begin
        e = expv[k][OW-1:0];
        n_cmp++;
        if (y !== e) begin
          n_bad++;
          $display("FAIL value u%0d k=%0d: got %0d, required %0d", u, k, $signed(y), $signed(e));
        end
        n_cmp++;
        if (l !== (k == n - 1)) begin
          n_bad++;
          $display("FAIL last u%0d k=%0d: got %b, required %b", u, k, l, (k == n - 1));
        end
        if (k == n - 1) en[u] = 1'b0;
        k++;
        started = 1;
      end
      stall = v && !xfer;
      py = y;
      pl = l;
    end
    n_cmp++;
    if (k < n) begin
      n_bad++;
      $display("FAIL recv_timeout u%0d: received %0d, required %0d", u, k, n);
    end
    @(negedge CLK);
    en[u] = 1'b0;
    ro[u] = 1'b0;
    n_cmp++;
    if (vl_of(u) !== 1'b0 || ri_of(u) !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_return u%0d: VALID %b READYI %b, required 0 1", u, vl_of(u), ri_of(u));
    end
  endtask

  task automatic run_block(input int u, input int m4, input longint x[16], input int pct,
                           input bit noise, input bit keep);
    longint y[16];
    int acc;
    model(m4, (m4 != 0) && halve_of(u), x, y);
    send_block(u, m4, x, (m4 != 0) ? 16 : 4, noise, acc);
    recv_block(u, m4, y, pct, acc, keep);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({vl0, ri0, ls0} !== 3'b000 || yy0 !== '0) begin
      n_bad++;
      $display("FAIL reset_u0: V/RI/L=%b%b%b Y=%0d, required 000 0", vl0, ri0, ls0, yy0);
    end
    n_cmp++;
    if ({vl1, ri1, vl2, ri2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_u12: %b, required 0000", {vl1, ri1, vl2, ri2});
    end
    RESET_N = 1'b1;
    #1;
    n_cmp++;
    if (ri0 !== 1'b0) begin
      n_bad++;
      $display("FAIL readyi_release: got %b before first edge, required 0", ri0);
    end
    @(negedge CLK);
    n_cmp++;
    if (ri0 !== 1'b1 || vl0 !== 1'b0) begin
      n_bad++;
      $display("FAIL readyi_rise: READYI %b VALID %b, required 1 0", ri0, vl0);
    end
  endtask

  task automatic test_2x2_known();
    longint x[16];
    for (int i = 0; i < 16; i++) x[i] = 0;
    for (int i = 0; i < 4; i++) x[i] = i + 1;
    run_block(0, 0, x, 100, 0, 0);
    run_block(1, 0, x, 100, 0, 0);
  endtask

  task automatic test_4x4_const();
    longint x[16];
    for (int i = 0; i < 16; i++) x[i] = 1;
    run_block(1, 1, x, 100, 0, 0);
    run_block(0, 1, x, 100, 0, 0);
    for (int i = 0; i < 16; i++) x[i] = -32768;
    run_block(1, 1, x, 100, 0, 0);
    run_block(0, 1, x, 100, 0, 0);
  endtask

  task automatic test_backpressure();
    longint x[16];
    for (int b = 0; b < 6; b++) begin
      rand_block(x);
      run_block(b % 2, int'($urandom_range(1)), x, 50, 0, 0);
    end
  endtask

  task automatic test_together();
    longint x[16];
    for (int b = 0; b < 4; b++) begin
      rand_block(x);
      run_block(2, (b % 2 == 0) ? 1 : 0, x, 30, 0, 0);
    end
  endtask

  task automatic test_mode_latch();
    longint x[16];
    rand_block(x);
    run_block(0, 0, x, 60, 1, 1);
    rand_block(x);
    run_block(0, 1, x, 60, 1, 1);
    rand_block(x);
    run_block(0, 0, x, 100, 0, 0);
  endtask

  task automatic test_reset_abort();
    longint x[16];
    int acc;
    int budget;
    rand_block(x);
    send_block(0, 1, x, 5, 0, acc);
    @(negedge CLK);
    en[0] = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (vl0 !== 1'b0 || yy0 !== '0 || ri0 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_load: V %b Y %0d RI %b, required 0 0 0", vl0, $signed(yy0), ri0);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    rand_block(x);
    run_block(0, 0, x, 100, 0, 0);

    for (int i = 0; i < 16; i++) x[i] = 1;
    send_block(0, 1, x, 16, 0, acc);
    @(negedge CLK);
    en[0] = 1'b0;
    ro[0] = 1'b0;
    budget = 0;
    while (vl0 !== 1'b1 && budget < 30) begin
      @(negedge CLK);
      budget++;
    end
    n_cmp++;
    if (vl0 !== 1'b1 || yy0 !== 20'd8) begin
      n_bad++;
      $display("FAIL abort_out_setup: V %b Y %0d, required 1 8", vl0, $signed(yy0));
    end
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (vl0 !== 1'b0 || yy0 !== '0 || ls0 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_out: V %b Y %0d L %b, required 0 0 0", vl0, $signed(yy0), ls0);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    rand_block(x);
    run_block(0, 0, x, 100, 0, 0);
  endtask

  task automatic test_back_to_back();
    longint x[16];
    for (int b = 0; b < 3; b++) begin
      rand_block(x);
      run_block(0, int'($urandom_range(1)), x, 100, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_2x2_known();
    test_4x4_const();
    test_backpressure();
    test_together();
    test_mode_latch();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
